lc_transition_ctrl: RTL

// - Sequences life-cycle state transitions onto the replicated decoded-state register ext_state_q.
//   The register holds DecLcStateNumRep copies of a DecLcStateWidth-bit decoded state.
// - Accepts one transition request at a time and checks it for legality.
// - Programs the replicas one per cycle, then verifies that all replicas agree.
// - Sits between the life-cycle request interface and every consumer of the decoded state.

---
 rtl/lc_transition_ctrl_if.sv | 35 +++
 rtl/lc_transition_ctrl.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/lc_transition_ctrl_if.sv
// Request/response handshake between the life-cycle requester and the
// transition controller.
//
// Handshake rules: a request transfers on a rising clock edge where
// req_valid && req_ready are both 1; the requester holds req_target stable
// while req_valid is high, and req_ready never depends combinationally on
// req_valid. resp_valid is a one-cycle pulse per finished request and
// resp_err is only meaningful while resp_valid is 1.
interface lc_transition_ctrl_if #(
    parameter int TargetWidth = 5
);
    logic                   req_valid;
    logic                   req_ready;
    logic [TargetWidth-1:0] req_target;
    logic                   resp_valid;
    logic                   resp_err;

    // Requester side
    modport master (
        output req_valid,
        output req_target,
        input  req_ready,
        input  resp_valid,
        input  resp_err
    );

    // Controller side
    modport slave (
        input  req_valid,
        input  req_target,
        output req_ready,
        output resp_valid,
        output resp_err
    );
endinterface

// File: rtl/lc_transition_ctrl.sv
// Life-cycle transition controller: accepts one transition request at a
// time, checks it for legality, programs the replicated decoded-state
// register one replica per cycle, then verifies that all replicas agree.
// Escalation forces every replica to the Escalate code and parks the FSM
// until reset.
module lc_transition_ctrl #(
    parameter int NumLcStates        = 21,
    parameter int DecLcStateWidth    = 5,
    parameter int DecLcStateNumRep   = 6,
    parameter int ExtDecLcStateWidth = DecLcStateNumRep * DecLcStateWidth
) (
    input  logic                          clk_i,
    input  logic                          rst_ni,
    lc_transition_ctrl_if.slave           req_if,
    input  logic                          escalate_i,
    output logic [DecLcStateWidth-1:0]    dec_state_o,
    output logic [ExtDecLcStateWidth-1:0] ext_state_o,
    output logic                          busy_o,
    output logic [2:0]                    state_o
);

    // Special decoded codes that sit just above the programmable range.
    localparam logic [DecLcStateWidth-1:0] MaxProgState = DecLcStateWidth'(NumLcStates - 1);
    localparam logic [DecLcStateWidth-1:0] DecPostTrans = DecLcStateWidth'(NumLcStates);
    localparam logic [DecLcStateWidth-1:0] DecEscalate  = DecLcStateWidth'(NumLcStates + 1);
    localparam logic [DecLcStateWidth-1:0] DecInvalid   = DecLcStateWidth'(NumLcStates + 2);
    localparam logic [2:0]                 LastRep      = 3'(DecLcStateNumRep - 1);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        CHECK   = 3'd1,
        PROGRAM = 3'd2,
        VERIFY  = 3'd3,
        RESP    = 3'd4,
        ESC     = 3'd5
    } state_e;

    state_e                          state_q, state_d;
    logic [DecLcStateWidth-1:0]      tgt_q, tgt_d;
    logic [2:0]                      k_q, k_d;
    logic                            err_q, err_d;
    logic                            esc_resp_q, esc_resp_d;
    logic [ExtDecLcStateWidth-1:0]   ext_state_q, ext_state_d;

    logic                            all_equal;
    logic                            all_match_tgt;
    logic [DecLcStateWidth-1:0]      rep0;
    logic [DecLcStateWidth-1:0]      cur_state;
    logic                            legal;

    // Replica agreement: every replica against replica 0 and against the target.
    always_comb begin
        rep0          = ext_state_q[DecLcStateWidth-1:0];
        all_equal     = 1'b1;
        all_match_tgt = 1'b1;
        for (int i = 0; i < DecLcStateNumRep; i++) begin
            if (ext_state_q[i*DecLcStateWidth +: DecLcStateWidth] != rep0) begin
                all_equal = 1'b0;
            end
            if (ext_state_q[i*DecLcStateWidth +: DecLcStateWidth] != tgt_q) begin
                all_match_tgt = 1'b0;
            end
        end
        cur_state = all_equal ? rep0 : DecInvalid;
    end

    // Legal only as a strictly forward move into the programmable range from a
    // consistent current state.
    always_comb begin
        legal = (tgt_q <= MaxProgState) && (tgt_q > cur_state) && (cur_state != DecInvalid);
    end

    // Next-state logic; escalation overrides everything except the ESC park state.
    always_comb begin
        state_d     = state_q;
        tgt_d       = tgt_q;
        k_d         = k_q;
        err_d       = err_q;
        esc_resp_d  = 1'b0;
        ext_state_d = ext_state_q;

        if (state_q == ESC) begin
            state_d = ESC;
        end else if (escalate_i) begin
            // A request still being worked on gets its error response in the
            // same cycle the override lands; a simultaneous accept is dropped.
            state_d     = ESC;
            ext_state_d = {DecLcStateNumRep{DecEscalate}};
            esc_resp_d  = (state_q == CHECK) || (state_q == PROGRAM) || (state_q == VERIFY);
        end else begin
            case (state_q)
                IDLE: begin
                    if (req_if.req_valid) begin
                        tgt_d   = req_if.req_target;
                        err_d   = 1'b0;
                        state_d = CHECK;
                    end
                end
                CHECK: begin
                    if (legal) begin
                        k_d     = 3'd0;
                        state_d = PROGRAM;
                    end else begin
                        err_d   = 1'b1;
                        state_d = RESP;
                    end
                end
                PROGRAM: begin
                    for (int i = 0; i < DecLcStateNumRep; i++) begin
                        if (k_q == 3'(i)) begin
                            ext_state_d[i*DecLcStateWidth +: DecLcStateWidth] = tgt_q;
                        end
                    end
                    k_d = k_q + 3'd1;
                    if (k_q == LastRep) begin
                        state_d = VERIFY;
                    end
                end
                VERIFY: begin
                    err_d   = !all_match_tgt;
                    state_d = RESP;
                end
                RESP: begin
                    state_d = IDLE;
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    // State and datapath registers; reset abandons any operation silently.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q     <= IDLE;
            tgt_q       <= '0;
            k_q         <= 3'd0;
            err_q       <= 1'b0;
            esc_resp_q  <= 1'b0;
            ext_state_q <= '0;
        end else begin
            state_q     <= state_d;
            tgt_q       <= tgt_d;
            k_q         <= k_d;
            err_q       <= err_d;
            esc_resp_q  <= esc_resp_d;
            ext_state_q <= ext_state_d;
        end
    end

    // Output decode, all from registered state.
    always_comb begin
        req_if.req_ready  = (state_q == IDLE);
        req_if.resp_valid = (state_q == RESP) || esc_resp_q;
        req_if.resp_err   = req_if.resp_valid && (err_q || esc_resp_q);
        busy_o            = (state_q != IDLE) && (state_q != ESC);
        ext_state_o       = ext_state_q;
        state_o           = state_q;
        if (state_q == ESC) begin
            dec_state_o = DecEscalate;
        end else if ((state_q == PROGRAM) || (state_q == VERIFY)) begin
            dec_state_o = DecPostTrans;
        end else begin
            dec_state_o = cur_state;
        end
    end

endmodule
